// File: rtl/misr_commit_feeder_if.sv
// Commit-port and MISR-side bundle for misr_commit_feeder.
//   commit_valid        per-port commit strobe, bit 0 = port 0
//   commit_pc0/1        PC of the retired instruction on each port
//   commit_res0/1       writeback result on each port
//   data_misr           serialised word to the MISR data input
//   misr_valid          word valid, drives the MISR enable
// master = core/commit side, slave = feeder.
interface misr_commit_feeder_if #(
    parameter int NBIT_DATA = 64
) ();
    logic [1:0]           commit_valid;
    logic [NBIT_DATA-1:0] commit_pc0;
    logic [NBIT_DATA-1:0] commit_pc1;
    logic [NBIT_DATA-1:0] commit_res0;
    logic [NBIT_DATA-1:0] commit_res1;
    logic [NBIT_DATA-1:0] data_misr;
    logic                 misr_valid;

    modport master (
        output commit_valid, commit_pc0, commit_pc1, commit_res0, commit_res1,
        input  data_misr, misr_valid
    );

    modport slave (
        input  commit_valid, commit_pc0, commit_pc1, commit_res0, commit_res1,
        output data_misr, misr_valid
    );
endinterface

// File: rtl/misr_commit_feeder.sv
// Captures instructions retired on two commit ports into a small FIFO and
// serialises each entry as two words (PC, then result) towards the MISR.
// Overflowing commits are dropped and reported by a sticky flag and a
// saturating counter.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   en_i            capture enable (no pushes while low)
//   clear_i         synchronous flush of FIFO, FSM and status
//   bus             commit inputs and MISR word/valid outputs
//   level_o         FIFO occupancy
//   overflow_o      sticky: a commit was dropped
//   drop_cnt_o      dropped commits, saturating
//
// state  | meaning
// S_IDLE | nothing in flight; start a PC word when the FIFO holds an entry
// S_PC   | PC word on the output; result word goes out next, head popped
// S_RES  | result word on the output; chain the next PC word if available
module misr_commit_feeder #(
    parameter int NBIT_DATA = 64,
    parameter int DEPTH     = 8,
    parameter int NBIT_CNT  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    clear_i,
    misr_commit_feeder_if.slave     bus,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    overflow_o,
    output logic [NBIT_CNT-1:0]     drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PC, S_RES} state_t;

    state_t               state_q, state_nxt;
    logic [NBIT_DATA-1:0] mem_pc  [DEPTH];
    logic [NBIT_DATA-1:0] mem_res [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q, free, n_push;
    logic [NBIT_DATA-1:0] data_q, data_nxt;
    logic                 valid_q, valid_nxt;
    logic                 overflow_q;
    logic [NBIT_CNT-1:0]  drop_cnt_q;
    logic [NBIT_CNT:0]    drop_sum;
    logic                 v0, v1, pop;
    logic [1:0]           n_valid, n_drop;

    // Free space uses the registered level only; a same-cycle pop does not help.
    always_comb begin
        v0      = en_i & bus.commit_valid[0];
        v1      = en_i & bus.commit_valid[1];
        n_valid = {1'b0, v0} + {1'b0, v1};
        free    = LW'(DEPTH) - level_q;
        n_push  = (LW'(n_valid) > free) ? free : LW'(n_valid);
        n_drop  = n_valid - n_push[1:0];
        pop     = (state_q == S_PC);
        drop_sum = {1'b0, drop_cnt_q} + {{(NBIT_CNT-1){1'b0}}, n_drop};
    end

    // Port 0 always takes the first free slot; port 1 alone also lands there.
    always_ff @(posedge clk_i) begin
        if (!clear_i && n_push != '0) begin
            mem_pc[wr_ptr_q]  <= v0 ? bus.commit_pc0  : bus.commit_pc1;
            mem_res[wr_ptr_q] <= v0 ? bus.commit_res0 : bus.commit_res1;
        end
        if (!clear_i && n_push == LW'(2)) begin
            mem_pc[wr_ptr_q + AW'(1)]  <= bus.commit_pc1;
            mem_res[wr_ptr_q + AW'(1)] <= bus.commit_res1;
        end
    end

    always_comb begin
        state_nxt = state_q;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_nxt = S_PC;
                    data_nxt  = mem_pc[rd_ptr_q];
                    valid_nxt = 1'b1;
                end
            end
            S_PC: begin
                state_nxt = S_RES;
                data_nxt  = mem_res[rd_ptr_q];
                valid_nxt = 1'b1;
            end
            S_RES: begin
                // level_q already reflects the pop, rd_ptr_q points at the next head
                if (level_q != '0) begin
                    state_nxt = S_PC;
                    data_nxt  = mem_pc[rd_ptr_q];
                    valid_nxt = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else if (clear_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(n_push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            level_q  <= level_q + n_push - LW'(pop);
            data_q   <= data_nxt;
            valid_q  <= valid_nxt;
            if (n_drop != 2'd0) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum[NBIT_CNT] ? '1 : drop_sum[NBIT_CNT-1:0];
            end
        end
    end

    assign bus.data_misr  = data_q;
    assign bus.misr_valid = valid_q;
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;
    assign drop_cnt_o     = drop_cnt_q;
endmodule

// File: tb/tb_misr_commit_feeder.sv
module tb_misr_commit_feeder;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          clear;
    logic [LW-1:0] level;
    logic          overflow;
    logic [15:0]   drop_cnt;

    misr_commit_feeder_if #(.NBIT_DATA(64)) bus ();

    misr_commit_feeder #(
        .NBIT_DATA (64),
        .DEPTH     (DEPTH),
        .NBIT_CNT  (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .clear_i    (clear),
        .bus        (bus),
        .level_o    (level),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of instructions, a word stream that emits
    // one word per cycle (result always right after its PC), the head leaving
    // the queue when its result word goes out.
    typedef struct {
        logic [63:0] pc;
        logic [63:0] res;
    } ent_t;

    ent_t        q[$];
    bit          res_pending;
    logic [63:0] m_data;
    bit          m_valid;
    bit          m_ovf;
    int          m_drop;

    task automatic model_reset();
        q.delete();
        res_pending = 0;
        m_data  = '0;
        m_valid = 0;
        m_ovf   = 0;
        m_drop  = 0;
    endtask

    task automatic model_edge();
        int   free;
        int   dropped;
        bit   do_pop;
        ent_t c[$];
        ent_t e;
        if (clear) begin
            model_reset();
            return;
        end
        free    = DEPTH - q.size();
        dropped = 0;
        do_pop  = 0;
        if (res_pending) begin
            m_data  = q[0].res;
            m_valid = 1;
            res_pending = 0;
            do_pop  = 1;
        end else if (q.size() > 0) begin
            m_data  = q[0].pc;
            m_valid = 1;
            res_pending = 1;
        end else begin
            m_valid = 0;
        end
        if (en && bus.commit_valid[0]) begin
            e.pc = bus.commit_pc0; e.res = bus.commit_res0; c.push_back(e);
        end
        if (en && bus.commit_valid[1]) begin
            e.pc = bus.commit_pc1; e.res = bus.commit_res1; c.push_back(e);
        end
        if (do_pop) void'(q.pop_front());
        foreach (c[i]) begin
            if (free > 0) begin
                q.push_back(c[i]);
                free--;
            end else begin
                dropped++;
            end
        end
        if (dropped > 0) begin
            m_ovf  = 1;
            m_drop = (m_drop + dropped > 65535) ? 65535 : m_drop + dropped;
        end
    endtask

    task automatic compare_model();
        check("valid",    64'(bus.misr_valid), 64'(m_valid));
        check("data",     bus.data_misr,       m_data);
        check("level",    64'(level),          64'(q.size()));
        check("overflow", 64'(overflow),       64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt),       64'(m_drop));
    endtask

    task automatic set_commit(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] res0,
                              input logic [63:0] pc1, input logic [63:0] res1);
        bus.commit_valid = v;
        bus.commit_pc0   = pc0;
        bus.commit_res0  = res0;
        bus.commit_pc1   = pc1;
        bus.commit_res1  = res1;
    endtask

    task automatic idle();
        set_commit(2'b00, '0, '0, '0, '0);
    endtask

    // Inputs are set at the falling edge, the model advances for the coming
    // rising edge, and outputs are compared at the next falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    localparam logic [3:0] PAT [24] = '{3, 1, 3, 2, 0, 3, 3, 1, 0, 0, 2, 3,
                                        1, 3, 0, 0, 0, 1, 2, 3, 3, 3, 0, 0};

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        clear = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(bus.misr_valid), 64'd0);
        check("reset_data",  bus.data_misr,       64'd0);
        check("reset_level", 64'(level),          64'd0);
        rst_n = 1'b1;
        compare_model();

        // single commit: valid at t+2 (pc) and t+3 (res), low at t+4
        set_commit(2'b01, 64'h1000, 64'hAA, '0, '0);
        cycle();
        check("single_level_t1", 64'(level), 64'd1);
        idle();
        cycle();
        check("single_pc_t2", bus.data_misr, 64'h1000);
        check("single_v_t2",  64'(bus.misr_valid), 64'd1);
        cycle();
        check("single_res_t3", bus.data_misr, 64'hAA);
        cycle();
        check("single_v_t4",     64'(bus.misr_valid), 64'd0);
        check("single_level_t4", 64'(level),          64'd0);

        // dual commit in one cycle
        set_commit(2'b11, 64'h10, 64'h1, 64'h20, 64'h2);
        cycle();
        idle();
        cycle(); check("dual_w0", bus.data_misr, 64'h10);
        cycle(); check("dual_w1", bus.data_misr, 64'h1);
        cycle(); check("dual_w2", bus.data_misr, 64'h20);
        cycle(); check("dual_w3", bus.data_misr, 64'h2);
        check("dual_v3", 64'(bus.misr_valid), 64'd1);
        cycle(); check("dual_end", 64'(bus.misr_valid), 64'd0);

        // overflow: three dual cycles into a 4-deep FIFO
        for (int k = 0; k < 3; k++) begin
            set_commit(2'b11, 64'h100 + 64'(2*k), 64'h200 + 64'(2*k),
                              64'h101 + 64'(2*k), 64'h201 + 64'(2*k));
            cycle();
        end
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        check("ovf_data", bus.data_misr, 64'h200);
        idle();
        repeat (9) cycle();
        check("ovf_drained", 64'(level), 64'd0);

        // capture disabled
        en = 1'b0;
        set_commit(2'b11, 64'h300, 64'h301, 64'h302, 64'h303);
        repeat (2) cycle();
        check("en_level", 64'(level),          64'd0);
        check("en_valid", 64'(bus.misr_valid), 64'd0);
        check("en_drop",  64'(drop_cnt),       64'd2);
        en = 1'b1;
        idle();

        // mixed commit patterns
        for (int k = 0; k < 24; k++) begin
            set_commit(PAT[k][1:0], 64'h1000 + 64'(4*k), 64'h2000 + 64'(4*k),
                                    64'h1001 + 64'(4*k), 64'h2001 + 64'(4*k));
            cycle();
        end
        idle();
        repeat (12) cycle();

        // clear while in S_PC with 3 entries and a simultaneous commit
        set_commit(2'b11, 64'h900, 64'h9, 64'hA00, 64'hA);
        cycle();
        set_commit(2'b01, 64'hB00, 64'hB, '0, '0);
        cycle();
        check("clr_pre_level", 64'(level),    64'd3);
        check("clr_pre_data",  bus.data_misr, 64'h900);
        check("clr_pre_ovf",   64'(overflow), 64'd1);
        clear = 1'b1;
        set_commit(2'b11, 64'hC00, 64'hC, 64'hD00, 64'hD);
        cycle();
        check("clr_valid", 64'(bus.misr_valid), 64'd0);
        check("clr_data",  bus.data_misr,       64'd0);
        check("clr_level", 64'(level),          64'd0);
        check("clr_ovf",   64'(overflow),       64'd0);
        check("clr_drop",  64'(drop_cnt),       64'd0);
        clear = 1'b0;
        idle();
        repeat (2) cycle();

        // asynchronous reset during S_RES
        set_commit(2'b11, 64'h500, 64'h5, 64'h600, 64'h6);
        cycle();
        idle();
        cycle(); check("rst_pre_pc",  bus.data_misr, 64'h500);
        cycle(); check("rst_pre_res", bus.data_misr, 64'h5);
        check("rst_pre_level", 64'(level), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(bus.misr_valid), 64'd0);
        check("rst_data",  bus.data_misr,       64'd0);
        check("rst_level", 64'(level),          64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_model();
        set_commit(2'b10, '0, '0, 64'h700, 64'h7);
        cycle();
        check("post_rst_level", 64'(level), 64'd1);
        idle();
        cycle(); check("post_rst_pc",  bus.data_misr, 64'h700);
        cycle(); check("post_rst_res", bus.data_misr, 64'h7);
        cycle(); check("post_rst_end", 64'(bus.misr_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
